// File: rtl/nabp_mapper_pkg.sv
// Shared definitions for the NABP mapper address generator.
// Holds the FSM state encoding, default widths and fixed-point format, the
// valid angle range, and the accumulator width rule used by the walker.
package nabp_mapper_pkg;

    localparam int unsigned ANGLE_W_DEF  = 8;
    localparam int unsigned PART_W_DEF   = 16;
    localparam int unsigned BASE_W_DEF   = 16;
    localparam int unsigned FRAC_W_DEF   = 8;
    localparam int unsigned ADDR_W_DEF   = 8;
    localparam int unsigned NUM_COLS_DEF = 256;
    localparam int unsigned LUT_LAT_DEF  = 2;

    // Legal projection angles are 0..ANGLE_RANGE-1.
    localparam int unsigned ANGLE_RANGE = 180;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Wide enough that base + NUM_COLS * part never wraps.
    function automatic int unsigned acc_width(input int unsigned part_w,
                                              input int unsigned base_w,
                                              input int unsigned num_cols);
        return ((part_w > base_w) ? part_w : base_w) + $clog2(num_cols) + 1;
    endfunction

endpackage

// File: rtl/nabp_mapper_accu.sv
// Fixed-point column accumulator for the mapper address generator.
// Ports:
//   clk, reset        clock, async active-high reset
//   load_i            capture part_i and sign-extended base_i
//   step_i            accumulator += captured part
//   part_i, base_i    LUT increment and base offset (two's complement)
//   addr_o            integer part of the accumulator, truncated to ADDR_W
//   in_range_o        integer part lies in 0..2**ADDR_W-1
// Macro NABP_MAPPER_ROUND_EN: pre-bias the loaded base by one half so the
// floor extraction becomes round-half-up; otherwise plain floor.
module nabp_mapper_accu
    import nabp_mapper_pkg::*;
#(
    parameter int unsigned PART_W = PART_W_DEF,
    parameter int unsigned BASE_W = BASE_W_DEF,
    parameter int unsigned FRAC_W = FRAC_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned ACC_W  = acc_width(PART_W_DEF, BASE_W_DEF, NUM_COLS_DEF)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [PART_W-1:0] part_i,
    input  logic [BASE_W-1:0] base_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              in_range_o
);

    localparam int unsigned INT_HI = FRAC_W + ADDR_W;

    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [PART_W-1:0] part_q, part_d;
    logic [ACC_W-1:0]  base_ext;
    logic [ACC_W-1:0]  part_ext;
    logic [ACC_W-1:0]  load_val;

    assign base_ext = {{(ACC_W - BASE_W){base_i[BASE_W-1]}}, base_i};
    assign part_ext = {{(ACC_W - PART_W){part_q[PART_W-1]}}, part_q};

`ifdef NABP_MAPPER_ROUND_EN
    localparam logic [ACC_W-1:0] HALF = ACC_W'(2 ** (FRAC_W - 1));
    assign load_val = base_ext + HALF;
`else
    assign load_val = base_ext;
`endif

    // Load / step / hold.
    always_comb begin
        acc_d  = acc_q;
        part_d = part_q;
        if (load_i) begin
            acc_d  = load_val;
            part_d = part_i;
        end else if (step_i) begin
            acc_d = acc_q + part_ext;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q  <= '0;
            part_q <= '0;
        end else begin
            acc_q  <= acc_d;
            part_q <= part_d;
        end
    end

    // Floor extraction is just a bit-slice of the two's complement value.
    assign addr_o     = acc_q[INT_HI-1:FRAC_W];
    // In range only when every bit above the address field (sign included) is zero.
    assign in_range_o = ~|acc_q[ACC_W-1:INT_HI];

endmodule

// File: rtl/nabp_mapper_addr_gen.sv
// Mapper address generator: fetches per-angle increment/base from the LUT and
// walks one line-buffer address per column with valid/ready backpressure.
// Ports:
//   clk, reset                      clock, async active-high reset
//   angle, angle_valid, angle_ready angle request handshake (ready only in IDLE)
//   mp_angle                        angle bus to the LUT, stable through FETCH/RUN
//   mp_accu_part, mp_accu_base      LUT responses, valid LUT_LAT cycles later
//   lb_addr, lb_in_range, lb_col    output beat payload
//   lb_valid, lb_ready              output beat handshake
//   done                            one-cycle pulse after the last column
// Macro NABP_MAPPER_ROUND_EN (in nabp_mapper_accu): round-to-nearest addresses.
module nabp_mapper_addr_gen
    import nabp_mapper_pkg::*;
#(
    parameter int unsigned ANGLE_W  = ANGLE_W_DEF,
    parameter int unsigned PART_W   = PART_W_DEF,
    parameter int unsigned BASE_W   = BASE_W_DEF,
    parameter int unsigned FRAC_W   = FRAC_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned NUM_COLS = NUM_COLS_DEF,
    parameter int unsigned LUT_LAT  = LUT_LAT_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [ANGLE_W-1:0]          angle,
    input  logic                        angle_valid,
    output logic                        angle_ready,
    output logic [ANGLE_W-1:0]          mp_angle,
    input  logic [PART_W-1:0]           mp_accu_part,
    input  logic [BASE_W-1:0]           mp_accu_base,
    output logic [ADDR_W-1:0]           lb_addr,
    output logic                        lb_in_range,
    output logic [$clog2(NUM_COLS)-1:0] lb_col,
    output logic                        lb_valid,
    input  logic                        lb_ready,
    output logic                        done
);

    localparam int unsigned COL_W  = $clog2(NUM_COLS);
    localparam int unsigned WAIT_W = $clog2(LUT_LAT + 1);
    localparam int unsigned ACC_W  = acc_width(PART_W, BASE_W, NUM_COLS);

    state_e             state_q;
    logic               angle_ready_q;
    logic [ANGLE_W-1:0] mp_angle_q;
    logic [WAIT_W-1:0]  wait_q;
    logic               lb_valid_q;
    logic [COL_W-1:0]   lb_col_q;
    logic               done_q;

    logic load_c;
    logic step_c;
    logic in_range_c;

    // LUT output is captured on the cycle the wait counter reaches LUT_LAT.
    assign load_c = (state_q == ST_FETCH) && (wait_q == WAIT_W'(LUT_LAT));
    assign step_c = (state_q == ST_RUN) && lb_ready;

    // Control FSM with registered handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            angle_ready_q <= 1'b1;
            mp_angle_q    <= '0;
            wait_q        <= '0;
            lb_valid_q    <= 1'b0;
            lb_col_q      <= '0;
            done_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (angle_valid) begin
                        mp_angle_q    <= angle;
                        wait_q        <= '0;
                        lb_col_q      <= '0;
                        angle_ready_q <= 1'b0;
                        state_q       <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (load_c) begin
                        lb_valid_q <= 1'b1;
                        state_q    <= ST_RUN;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (lb_ready) begin
                        lb_col_q <= lb_col_q + COL_W'(1);
                        if (lb_col_q == COL_W'(NUM_COLS - 1)) begin
                            lb_valid_q <= 1'b0;
                            done_q     <= 1'b1;
                            state_q    <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    angle_ready_q <= 1'b1;
                    state_q       <= ST_IDLE;
                end
                default: begin
                    angle_ready_q <= 1'b1;
                    lb_valid_q    <= 1'b0;
                    state_q       <= ST_IDLE;
                end
            endcase
        end
    end

    nabp_mapper_accu #(
        .PART_W (PART_W),
        .BASE_W (BASE_W),
        .FRAC_W (FRAC_W),
        .ADDR_W (ADDR_W),
        .ACC_W  (ACC_W)
    ) u_accu (
        .clk        (clk),
        .reset      (reset),
        .load_i     (load_c),
        .step_i     (step_c),
        .part_i     (mp_accu_part),
        .base_i     (mp_accu_base),
        .addr_o     (lb_addr),
        .in_range_o (in_range_c)
    );

    assign angle_ready = angle_ready_q;
    assign mp_angle    = mp_angle_q;
    assign lb_valid    = lb_valid_q;
    assign lb_col      = lb_col_q;
    assign done        = done_q;
    // Range flag only means something on a live beat.
    assign lb_in_range = in_range_c & lb_valid_q;

endmodule

// File: tb/tb_nabp_mapper_addr_gen.sv
`timescale 1ns/1ps
module tb_nabp_mapper_addr_gen;
    import nabp_mapper_pkg::*;

    localparam int unsigned NUM_COLS = 256;
    localparam int unsigned LUT_LAT  = 2;
    localparam int unsigned FRAC_W   = 8;
    localparam int unsigned ADDR_W   = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  angle;
    logic        angle_valid;
    logic        angle_ready;
    logic [7:0]  mp_angle;
    logic [15:0] mp_accu_part;
    logic [15:0] mp_accu_base;
    logic [7:0]  lb_addr;
    logic        lb_in_range;
    logic [7:0]  lb_col;
    logic        lb_valid;
    logic        lb_ready;
    logic        done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nabp_mapper_addr_gen dut (
        .clk          (clk),
        .reset        (reset),
        .angle        (angle),
        .angle_valid  (angle_valid),
        .angle_ready  (angle_ready),
        .mp_angle     (mp_angle),
        .mp_accu_part (mp_accu_part),
        .mp_accu_base (mp_accu_base),
        .lb_addr      (lb_addr),
        .lb_in_range  (lb_in_range),
        .lb_col       (lb_col),
        .lb_valid     (lb_valid),
        .lb_ready     (lb_ready),
        .done         (done)
    );

    // Registered LUT responder: two register stages on the angle bus.
    logic [15:0] part_tab [256];
    logic [15:0] base_tab [256];
    logic [7:0]  lut_a1, lut_a2;
    always @(posedge clk) begin
        lut_a1 <= mp_angle;
        lut_a2 <= lut_a1;
    end
    assign mp_accu_part = part_tab[lut_a2];
    assign mp_accu_base = base_tab[lut_a2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Column k position = base + k*part in real-valued fixed point, floored.
    function automatic void model(input logic [15:0] p, input logic [15:0] b, input int k,
                                  output logic [7:0] addr, output logic inr);
        longint v;
        longint ip;
        v = longint'($signed(b)) + longint'(k) * longint'($signed(p));
`ifdef NABP_MAPPER_ROUND_EN
        v = v + (longint'(1) <<< (FRAC_W - 1));
`endif
        ip   = v >>> FRAC_W;
        addr = ADDR_W'(ip);
        inr  = (ip >= 0) && (ip < (longint'(1) <<< ADDR_W));
    endfunction

    task automatic do_walk(input logic [7:0] a, input logic [7:0] a_next, input int ready_pct,
                           input bit hold_valid, input bit check_lat, input int abort_at,
                           input int probe_col, input logic [7:0] probe_addr, input logic probe_inr);
        int   lat;
        int   k;
        int   cyc;
        logic [7:0] ea;
        logic ei;
        bit   acc;
        @(negedge clk);
        chk("idle_ready", 64'(angle_ready), 64'(1'b1));
        angle       = a;
        angle_valid = 1'b1;
        @(negedge clk);
        if (hold_valid) angle = a_next;
        else angle_valid = 1'b0;
        chk("fetch", 64'({angle_ready, lb_valid, mp_angle}), 64'({1'b0, 1'b0, a}));
        lat = 1;
        while (!lb_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (check_lat) chk("latency", 64'(lat), 64'(LUT_LAT + 2));
        if (!lb_valid) begin
            chk("valid_timeout", 64'(lb_valid), 64'(1'b1));
            return;
        end
        k   = 0;
        cyc = 0;
        while (k < NUM_COLS && cyc < 20000) begin
            if (k == abort_at) return;
            model(part_tab[a], base_tab[a], k, ea, ei);
            chk($sformatf("beat a=%0d col=%0d", a, k),
                64'({lb_valid, lb_addr, lb_in_range, lb_col, done, angle_ready, mp_angle}),
                64'({1'b1, ea, ei, 8'(k), 1'b0, 1'b0, a}));
            if (k == probe_col)
                chk($sformatf("probe a=%0d col=%0d", a, k),
                    64'({lb_addr, lb_in_range}), 64'({probe_addr, probe_inr}));
            acc      = ($urandom_range(99) < ready_pct);
            lb_ready = acc;
            @(negedge clk);
            cyc++;
            if (acc) k++;
        end
        lb_ready = 1'b0;
        if (k < NUM_COLS) begin
            chk("walk_timeout", 64'(k), 64'(NUM_COLS));
            return;
        end
        chk("done_pulse", 64'({done, lb_valid, lb_in_range, angle_ready}), 64'(4'b1000));
        @(negedge clk);
        chk("back_idle", 64'({done, lb_valid, angle_ready}), 64'(3'b001));
    endtask

    typedef struct {
        logic [7:0]  angle;
        logic [15:0] part;
        logic [15:0] base;
        int          probe_col;
        logic [7:0]  exp_addr;
        logic        exp_inr;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int   cyc;
        logic [7:0] a;

        reset       = 1'b1;
        angle       = '0;
        angle_valid = 1'b0;
        lb_ready    = 1'b0;
        for (int i = 0; i < 256; i++) begin
            part_tab[i] = 16'h0100;
            base_tab[i] = 16'h0000;
        end

        // Hand-derived probe points (floor vs round-half-up).
        vecs[0] = '{8'd0,   16'h0100, 16'h0000, 255, 8'hFF, 1'b1};
        vecs[4] = '{8'd120, 16'h0200, 16'h1000, 120, 8'h00, 1'b0};
        vecs[5] = '{8'd179, 16'hFF00, 16'h0A00, 11,  8'hFF, 1'b0};
`ifdef NABP_MAPPER_ROUND_EN
        vecs[1] = '{8'd45,  16'h0080, 16'hFE00, 3,   8'h00, 1'b1};
        vecs[2] = '{8'd45,  16'h0080, 16'hFE00, 5,   8'h01, 1'b1};
        vecs[3] = '{8'd90,  16'h0080, 16'h0000, 1,   8'h01, 1'b1};
        vecs[6] = '{8'd200, 16'h0033, 16'h7FFF, 0,   8'h80, 1'b1};
`else
        vecs[1] = '{8'd45,  16'h0080, 16'hFE00, 3,   8'hFF, 1'b0};
        vecs[2] = '{8'd45,  16'h0080, 16'hFE00, 5,   8'h00, 1'b1};
        vecs[3] = '{8'd90,  16'h0080, 16'h0000, 1,   8'h00, 1'b1};
        vecs[6] = '{8'd200, 16'h0033, 16'h7FFF, 0,   8'h7F, 1'b1};
`endif

        repeat (2) @(negedge clk);
        chk("reset_state",
            64'({angle_ready, mp_angle, lb_valid, lb_addr, lb_in_range, lb_col, done}),
            64'({1'b1, 8'd0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0}));
        reset = 1'b0;

        // Table-driven walks, continuous ready.
        for (int i = 0; i < 7; i++) begin
            part_tab[vecs[i].angle] = vecs[i].part;
            base_tab[vecs[i].angle] = vecs[i].base;
            do_walk(vecs[i].angle, 8'd0, 100, 1'b0, (i == 0), NUM_COLS,
                    vecs[i].probe_col, vecs[i].exp_addr, vecs[i].exp_inr);
        end

        // Randomised LUT contents, 50% backpressure.
        for (int r = 0; r < 6; r++) begin
            a = (r % 2 == 0) ? 8'($urandom_range(ANGLE_RANGE - 1))
                             : 8'($urandom_range(255, ANGLE_RANGE));
            part_tab[a] = 16'($urandom);
            base_tab[a] = 16'($urandom);
            do_walk(a, 8'd0, 50, 1'b0, 1'b1, NUM_COLS, -1, 8'd0, 1'b0);
        end

        // Async reset in the middle of a walk.
        part_tab[30] = 16'h0100;
        base_tab[30] = 16'h0500;
        do_walk(8'd30, 8'd0, 100, 1'b0, 1'b0, 100, -1, 8'd0, 1'b0);
        chk("pre_reset_col", 64'(lb_col), 64'(100));
        #2 reset = 1'b1;
        #1;
        chk("async_reset",
            64'({angle_ready, mp_angle, lb_valid, lb_addr, lb_in_range, lb_col, done}),
            64'({1'b1, 8'd0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0}));
        lb_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("quiet_after_reset", 64'({done, lb_valid, angle_ready}), 64'(3'b001));
        end
        do_walk(8'd30, 8'd0, 100, 1'b0, 1'b1, NUM_COLS, 0, 8'h05, 1'b1);

        // angle_valid held high: second angle only taken once IDLE is back.
        part_tab[61] = 16'h0040;
        base_tab[61] = 16'h0000;
        do_walk(8'd60, 8'd61, 100, 1'b1, 1'b0, NUM_COLS, -1, 8'd0, 1'b0);
        @(negedge clk);
        chk("second_accept", 64'({angle_ready, mp_angle}), 64'({1'b0, 8'd61}));
        angle_valid = 1'b0;
        lb_ready    = 1'b1;
        cyc = 0;
        while (!done && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        chk("second_walk_done", 64'(done), 64'(1'b1));
        lb_ready = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nabp_mapper_addr_gen.md
Name: nabp_mapper_addr_gen

Overview:
- Initiator side of the mapper look-up-table interface: accepts one projection angle, drives it onto the LUT's angle bus, captures the returned per-column increment and base offset, then walks a fixed-point accumulator across every image column.
- Emits one line-buffer address per column, with valid/ready backpressure.
- Sits between the angle sequencer and the line buffer; the LUT is an external registered responder with fixed latency.

Parameters:
- ANGLE_W, 8: angle index width; legal angles 0..179.
- PART_W, 16: signed per-column increment width (two's complement).
- BASE_W, 16: signed base-offset width.
- FRAC_W, 8: fractional bits in both PART and BASE formats.
- ADDR_W, 8: line-buffer address width; line length is 2**ADDR_W.
- NUM_COLS, 256: columns emitted per angle.
- LUT_LAT, 2: cycles from mp_angle change to valid LUT outputs.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- angle  in  ANGLE_W  requested angle.
- angle_valid  in  1  angle request present.
- angle_ready  out  1  block can accept an angle (high only in IDLE).
- mp_angle  out  ANGLE_W  angle bus to the LUT.
- mp_accu_part  in  PART_W  LUT increment, valid LUT_LAT cycles after mp_angle.
- mp_accu_base  in  BASE_W  LUT base offset.
- lb_addr  out  ADDR_W  line-buffer address, integer part of the accumulator.
- lb_in_range  out  1  address lies within 0..2**ADDR_W-1.
- lb_col  out  log2(NUM_COLS)  column index of the current output.
- lb_valid  out  1  output beat valid.
- lb_ready  in  1  consumer accepts the beat.
- done  out  1  one-cycle pulse after the last column is accepted.

Behaviour:
- Reset values:
  - State IDLE; angle_ready=1; mp_angle=0.
  - lb_valid=0, lb_addr=0, lb_in_range=0, lb_col=0, done=0.
  - Accumulator 0, wait counter 0.
  - All values are restored immediately on reset assertion, including mid-walk; any partial walk is discarded and no done pulse is issued.
- States:
  - IDLE: on angle_valid, latch angle into mp_angle, clear the wait counter, go to FETCH. angle_ready is low in every other state.
  - FETCH: count LUT_LAT cycles. On the last count, capture mp_accu_part into a part register and sign-extend mp_accu_base into the accumulator, then go to RUN. mp_angle holds stable throughout FETCH and RUN.
  - RUN: lb_valid=1. Outputs are derived from registered state only:
    - lb_addr = accumulator bits [FRAC_W+ADDR_W-1:FRAC_W].
    - lb_in_range = accumulator non-negative and integer part < 2**ADDR_W.
    - On lb_valid && lb_ready: accumulator += part and lb_col += 1.
    - When the beat with lb_col==NUM_COLS-1 is accepted, go to DONE.
    - If lb_ready is low, all outputs hold unchanged.
  - DONE: done=1 for exactly one cycle; lb_valid=0; return to IDLE. angle_ready rises on the following cycle, so there is no back-to-back accept in the DONE cycle.
- Arithmetic:
  - Accumulator width ACC_W = max(PART_W,BASE_W) + log2(NUM_COLS) + 1, signed; it never overflows across a full walk.
  - Address extraction uses floor: arithmetic truncation of the fraction.
- Out-of-range handling: lb_addr is still driven with the truncated bits and lb_in_range=0; the consumer discards the beat.
- Angle input ≥180: accepted and passed to the LUT unchanged; the result is undefined but the walk still completes, so the handshake cannot deadlock.
- Latency: first lb_valid appears LUT_LAT+2 cycles after an accepted angle_valid.
- Throughput: one address per cycle under continuous lb_ready.

Optional Feature:
- Macro NABP_MAPPER_ROUND_EN.
- Defined: on the FETCH capture, 2**(FRAC_W-1) is added to the accumulator, so lb_addr rounds to nearest with halves rounding up; lb_in_range is evaluated on the rounded value.
- Undefined: floor truncation as described above. No port changes either way.

Decomposition:
- Shared package nabp_mapper_pkg:
  - State enum (IDLE/FETCH/RUN/DONE).
  - ACC_W derivation function.
  - Angle range constant 180.
  - Fixed-point format constants shared with the LUT generator.
- One natural sub-module: nabp_mapper_accu holds the accumulator register, handles load/step/hold, and produces the rounded/floored address plus the in-range flag.

Test Plan:
- Angle 0, part=1.0 (0x0100), base=0, lb_ready=1 → lb_addr 0,1,…,255, all in range; first valid at cycle LUT_LAT+2; done pulses once, one cycle after col 255 is accepted.
- Angle 45, part=0.5 (0x0080), base=-2.0 → addresses start 0xFE with in_range=0 for cols 0..3, then in_range=1 from col 4 (addr 0); addr 0 is repeated for col 5.
- Random lb_ready deasserted 50% of cycles → identical address sequence to the stall-free run; outputs stable while stalled; lb_col advances only on handshake.
- Assert reset at column 100 → all outputs return to reset values asynchronously; no done pulse; the next angle walk starts cleanly from its base.
- NABP_MAPPER_ROUND_EN with part=0x0080, base=0 → sequence 0,1,1,2,2,…; without the macro → 0,0,1,1,2,….
- angle_valid held high continuously → angle_ready low from the FETCH cycle through DONE; a second angle is accepted only after IDLE is re-entered.
